exec_alu_stage: RTL and testbench

- Execute stage sitting directly downstream of the register file.
- Consumes the two register read operands plus decoded control, computes the ALU result, and drives the register file write port (reg_write / write_register / write_data).
- Single-cycle logic ops and add/sub.
- Optional iterative 64-cycle multiplier; a valid/ready handshake stalls upstream while it runs.

---
 rtl/exec_alu_stage_if.sv | 44 ++++
 rtl/exec_alu_stage.sv | 228 ++++++++++++++++++++++
 tb/tb_exec_alu_stage.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/exec_alu_stage_if.sv
// -----------------------------------------------------------------------------
// exec_alu_stage_if
//   Bundle between the issue side and the execute stage.
//
//   Issue side -> stage : in_valid, alu_op, operand_a, operand_b, dest_reg, wb_en
//   Stage -> issue side : in_ready, busy
//   Stage -> reg file   : reg_write, write_register, write_data
//   Stage -> status     : flag_n, flag_z, flag_c, flag_v
//
//   master : the upstream/driver view (drives the operation, observes results)
//   slave  : the execute stage view
// -----------------------------------------------------------------------------
interface exec_alu_stage_if #(
    parameter int dataWidth    = 64,
    parameter int addressWidth = 5
);
    logic                    in_valid;
    logic                    in_ready;
    logic [3:0]              alu_op;
    logic [dataWidth-1:0]    operand_a;
    logic [dataWidth-1:0]    operand_b;
    logic [addressWidth-1:0] dest_reg;
    logic                    wb_en;
    logic                    reg_write;
    logic [addressWidth-1:0] write_register;
    logic [dataWidth-1:0]    write_data;
    logic                    flag_n;
    logic                    flag_z;
    logic                    flag_c;
    logic                    flag_v;
    logic                    busy;

    modport master (
        output in_valid, alu_op, operand_a, operand_b, dest_reg, wb_en,
        input  in_ready, reg_write, write_register, write_data,
        input  flag_n, flag_z, flag_c, flag_v, busy
    );

    modport slave (
        input  in_valid, alu_op, operand_a, operand_b, dest_reg, wb_en,
        output in_ready, reg_write, write_register, write_data,
        output flag_n, flag_z, flag_c, flag_v, busy
    );
endinterface

// File: rtl/exec_alu_stage.sv
// -----------------------------------------------------------------------------
// exec_alu_stage
//   Execute stage behind the register file. Takes the two read operands plus
//   decoded control, computes the ALU result and drives the register file
//   write port one cycle after acceptance. Writes to ZERO_REG (XZR) update
//   write_data and flags but never strobe reg_write.
//
//   Ports:
//     clock   : rising-edge clock
//     reset_n : asynchronous active-low reset
//     bus     : exec_alu_stage_if.slave (handshake, operands, write port, NZCV, busy)
//
//   Build option:
//     EXEC_MUL_EN - when defined, op 1000 runs a 64-iteration shift/add
//                   multiplier (IDLE/MUL_RUN FSM) and stalls upstream via
//                   in_ready. When undefined, op 1000 is an unknown op and
//                   in_ready/busy are tied to 1/0.
// -----------------------------------------------------------------------------
module exec_alu_stage #(
    parameter int dataWidth    = 64,
    parameter int addressWidth = 5,
    parameter int ZERO_REG     = 31
) (
    input logic              clock,
    input logic              reset_n,
    exec_alu_stage_if.slave  bus
);
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_ORR  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_PASS = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam int         MSB     = dataWidth - 1;

    logic [dataWidth-1:0]    writeDataQ, writeDataD;
    logic [addressWidth-1:0] writeRegQ, writeRegD;
    logic                    regWriteQ, regWriteD;
    // Flags packed as {N, Z, C, V}
    logic [3:0]              flagsQ, flagsD;

    logic                    accept;
    logic [dataWidth:0]      addSum;
    logic [dataWidth:0]      subSum;
    logic [dataWidth-1:0]    aluResult;
    logic                    aluC;
    logic                    aluV;
    logic                    aluKnown;

    logic                    isMul;
    logic                    mulDone;
    logic [dataWidth-1:0]    mulResult;
    logic [addressWidth-1:0] mulDest;
    logic                    mulWb;

    assign accept = bus.in_valid && bus.in_ready;

    // Extra top bit of each sum is the carry-out; SUB is a + ~b + 1 so its
    // carry means "no borrow".
    assign addSum = {1'b0, bus.operand_a} + {1'b0, bus.operand_b};
    assign subSum = {1'b0, bus.operand_a} + {1'b0, ~bus.operand_b} + {{dataWidth{1'b0}}, 1'b1};

    // Single-cycle ALU. Unknown codes (including MUL when the multiplier is
    // not built) give result 0 and force all flags to 0, so Z is not derived
    // from the zero result for them.
    always_comb begin
        aluResult = '0;
        aluC      = 1'b0;
        aluV      = 1'b0;
        aluKnown  = 1'b1;
        case (bus.alu_op)
            OP_AND:  aluResult = bus.operand_a & bus.operand_b;
            OP_ORR:  aluResult = bus.operand_a | bus.operand_b;
            OP_ADD: begin
                aluResult = addSum[MSB:0];
                aluC      = addSum[dataWidth];
                aluV      = (bus.operand_a[MSB] == bus.operand_b[MSB]) &&
                            (addSum[MSB] != bus.operand_a[MSB]);
            end
            OP_SUB: begin
                aluResult = subSum[MSB:0];
                aluC      = subSum[dataWidth];
                aluV      = (bus.operand_a[MSB] != bus.operand_b[MSB]) &&
                            (subSum[MSB] != bus.operand_a[MSB]);
            end
            OP_PASS: aluResult = bus.operand_b;
            OP_NOR:  aluResult = ~(bus.operand_a | bus.operand_b);
            default: aluKnown  = 1'b0;
        endcase
    end

`ifdef EXEC_MUL_EN
    localparam logic [3:0] OP_MUL   = 4'b1000;
    localparam int         CNT_W    = $clog2(dataWidth);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(dataWidth - 1);

    typedef enum logic {IDLE, MUL_RUN} state_t;

    state_t                  stateQ, stateD;
    logic [dataWidth-1:0]    mcandQ, mcandD;
    logic [dataWidth-1:0]    mplierQ, mplierD;
    logic [dataWidth-1:0]    accQ, accD;
    logic [dataWidth-1:0]    accStep;
    logic [CNT_W-1:0]        countQ, countD;
    logic [addressWidth-1:0] mulDestQ, mulDestD;
    logic                    mulWbQ, mulWbD;

    assign bus.in_ready = (stateQ == IDLE);
    assign bus.busy     = (stateQ == MUL_RUN);

    // The final iteration's add is folded straight into the written result so
    // the write lands on the same edge the counter wraps.
    assign accStep   = mplierQ[0] ? (accQ + mcandQ) : accQ;
    assign isMul     = (bus.alu_op == OP_MUL);
    assign mulDone   = (stateQ == MUL_RUN) && (countQ == LAST_COUNT);
    assign mulResult = accStep;
    assign mulDest   = mulDestQ;
    assign mulWb     = mulWbQ;

    // Multiplier FSM: latch operands on a MUL transfer, then one shift/add
    // step per cycle until the counter wraps.
    always_comb begin
        stateD   = stateQ;
        mcandD   = mcandQ;
        mplierD  = mplierQ;
        accD     = accQ;
        countD   = countQ;
        mulDestD = mulDestQ;
        mulWbD   = mulWbQ;
        case (stateQ)
            IDLE: begin
                if (accept && isMul) begin
                    mcandD   = bus.operand_a;
                    mplierD  = bus.operand_b;
                    accD     = '0;
                    countD   = '0;
                    mulDestD = bus.dest_reg;
                    mulWbD   = bus.wb_en;
                    stateD   = MUL_RUN;
                end
            end
            MUL_RUN: begin
                accD    = accStep;
                mcandD  = mcandQ << 1;
                mplierD = mplierQ >> 1;
                countD  = countQ + CNT_W'(1);
                if (countQ == LAST_COUNT) begin
                    stateD = IDLE;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    // Multiplier state; a reset mid-run simply drops the operation.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stateQ   <= IDLE;
            mcandQ   <= '0;
            mplierQ  <= '0;
            accQ     <= '0;
            countQ   <= '0;
            mulDestQ <= '0;
            mulWbQ   <= 1'b0;
        end else begin
            stateQ   <= stateD;
            mcandQ   <= mcandD;
            mplierQ  <= mplierD;
            accQ     <= accD;
            countQ   <= countD;
            mulDestQ <= mulDestD;
            mulWbQ   <= mulWbD;
        end
    end
`else
    assign bus.in_ready = 1'b1;
    assign bus.busy     = 1'b0;
    assign isMul        = 1'b0;
    assign mulDone      = 1'b0;
    assign mulResult    = '0;
    assign mulDest      = '0;
    assign mulWb        = 1'b0;
`endif

    // Write-port/flag update: either a multiply completing or a single-cycle
    // transfer (the two never coincide because in_ready is low while the
    // multiplier runs). Otherwise everything holds and reg_write drops.
    always_comb begin
        writeDataD = writeDataQ;
        writeRegD  = writeRegQ;
        flagsD     = flagsQ;
        regWriteD  = 1'b0;
        if (mulDone) begin
            writeDataD = mulResult;
            writeRegD  = mulDest;
            flagsD     = {mulResult[MSB], (mulResult == '0), 1'b0, 1'b0};
            regWriteD  = mulWb && (mulDest != addressWidth'(ZERO_REG));
        end else if (accept && !isMul) begin
            writeDataD = aluResult;
            writeRegD  = bus.dest_reg;
            flagsD     = aluKnown ? {aluResult[MSB], (aluResult == '0), aluC, aluV} : 4'b0000;
            regWriteD  = bus.wb_en && (bus.dest_reg != addressWidth'(ZERO_REG));
        end
    end

    // Output registers for the write port and NZCV.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            writeDataQ <= '0;
            writeRegQ  <= '0;
            regWriteQ  <= 1'b0;
            flagsQ     <= 4'b0000;
        end else begin
            writeDataQ <= writeDataD;
            writeRegQ  <= writeRegD;
            regWriteQ  <= regWriteD;
            flagsQ     <= flagsD;
        end
    end

    assign bus.reg_write      = regWriteQ;
    assign bus.write_register = writeRegQ;
    assign bus.write_data     = writeDataQ;
    assign bus.flag_n         = flagsQ[3];
    assign bus.flag_z         = flagsQ[2];
    assign bus.flag_c         = flagsQ[1];
    assign bus.flag_v         = flagsQ[0];
endmodule

// File: tb/tb_exec_alu_stage.sv
// -----------------------------------------------------------------------------
// tb_exec_alu_stage
//   Directed-vector bench for exec_alu_stage. The driver pushes each expected
//   write-port result, tagged with the cycle it should appear, into a queue;
//   an independent monitor pops and compares on the falling edge. Multiplier
//   vectors are selected by EXEC_MUL_EN to match the DUT build.
// -----------------------------------------------------------------------------
module tb_exec_alu_stage;
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_ORR  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_PASS = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_BAD  = 4'b0011;

    typedef struct {
        string       name;
        int unsigned due;
        logic [63:0] data;
        logic [4:0]  dest;
        logic        rw;
        logic [3:0]  nzcv;
    } expect_t;

    logic        clock;
    logic        reset_n;
    int unsigned cycleCount;
    int unsigned passCount;
    int unsigned totalChecks;
    bit          started;
    expect_t     scoreQ[$];

    exec_alu_stage_if #(.dataWidth(64), .addressWidth(5)) bus ();

    exec_alu_stage #(.dataWidth(64), .addressWidth(5), .ZERO_REG(31)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cycleCount++;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        totalChecks++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, actual, expected, cycleCount);
        end
    endtask

    // Monitor: compares the queued result on its due cycle, and otherwise
    // insists the write strobe is quiet.
    always @(negedge clock) begin
        if (started) begin
            if (scoreQ.size() > 0 && scoreQ[0].due == cycleCount) begin
                expect_t e;
                e = scoreQ.pop_front();
                checkOutput({e.name, "_rw"},   64'(bus.reg_write), 64'(e.rw));
                checkOutput({e.name, "_dest"}, 64'(bus.write_register), 64'(e.dest));
                checkOutput({e.name, "_data"}, bus.write_data, e.data);
                checkOutput({e.name, "_nzcv"},
                            64'({bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v}), 64'(e.nzcv));
            end else begin
                checkOutput("spurious_reg_write", 64'(bus.reg_write), 64'd0);
            end
        end
    end

    task automatic applyStimulus(input string name, input logic [3:0] op,
                                 input logic [63:0] a, input logic [63:0] b,
                                 input logic [4:0] dest, input logic wb,
                                 input logic [63:0] expData, input logic [3:0] expNzcv,
                                 input bit track);
        int budget;
        expect_t e;
        @(negedge clock);
        bus.in_valid  = 1'b1;
        bus.alu_op    = op;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.dest_reg  = dest;
        bus.wb_en     = wb;
        budget = 0;
        while (!bus.in_ready && budget < 200) begin
            @(negedge clock);
            budget++;
        end
        checkOutput({name, "_accept"}, 64'(bus.in_ready), 64'd1);
        if (bus.in_ready && track) begin
            e.name = name;
            e.data = expData;
            e.dest = dest;
            e.rw   = wb && (dest != 5'd31);
            e.nzcv = expNzcv;
`ifdef EXEC_MUL_EN
            e.due  = (op == OP_MUL) ? cycleCount + 65 : cycleCount + 1;
`else
            e.due  = cycleCount + 1;
`endif
            scoreQ.push_back(e);
        end
        @(posedge clock);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic drainQueue();
        int budget;
        budget = 0;
        while (scoreQ.size() > 0 && budget < 200) begin
            @(negedge clock);
            budget++;
        end
        checkOutput("queue_drained", 64'(scoreQ.size()), 64'd0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_reg_write"}, 64'(bus.reg_write), 64'd0);
        checkOutput({tag, "_write_register"}, 64'(bus.write_register), 64'd0);
        checkOutput({tag, "_write_data"}, bus.write_data, 64'd0);
        checkOutput({tag, "_flags"}, 64'({bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v}), 64'd0);
        checkOutput({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        checkOutput({tag, "_busy"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic pulseReset(input string tag);
        #2 reset_n = 1'b0;
        #1 checkResetState(tag);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        int stall;
        cycleCount    = 0;
        passCount     = 0;
        totalChecks   = 0;
        started       = 1'b0;
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.alu_op    = 4'b0000;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.dest_reg  = '0;
        bus.wb_en     = 1'b0;
        #3 checkResetState("por");
        @(negedge clock);
        reset_n = 1'b1;
        started = 1'b1;

        // Back-to-back single-cycle vectors; expected {N,Z,C,V} hand-derived.
        applyStimulus("add",      OP_ADD, 64'd5, 64'd7, 5'd3, 1'b1, 64'd12, 4'b0000, 1'b1);
        applyStimulus("sub_eq",   OP_SUB, 64'd3, 64'd3, 5'd4, 1'b1, 64'd0, 4'b0110, 1'b1);
        applyStimulus("sub_ovf",  OP_SUB, 64'h8000_0000_0000_0000, 64'd1, 5'd10, 1'b1,
                      64'h7FFF_FFFF_FFFF_FFFF, 4'b0011, 1'b1);
        applyStimulus("orr_xzr",  OP_ORR, 64'hF0, 64'h0F, 5'd31, 1'b1, 64'hFF, 4'b0000, 1'b1);
        applyStimulus("and_nowb", OP_AND, 64'hFF00, 64'h0FF0, 5'd1, 1'b0, 64'h0F00, 4'b0000, 1'b1);
        applyStimulus("add_carry", OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd5, 1'b1, 64'd0, 4'b0110, 1'b1);
        applyStimulus("add_ovf",  OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'd11, 1'b1,
                      64'h8000_0000_0000_0000, 4'b1001, 1'b1);
        applyStimulus("nor",      OP_NOR, 64'd0, 64'd0, 5'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 1'b1);
        applyStimulus("unknown",  OP_BAD, 64'd5, 64'd5, 5'd8, 1'b1, 64'd0, 4'b0000, 1'b1);
        applyStimulus("sub_borrow", OP_SUB, 64'd1, 64'd2, 5'd12, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 1'b1);
`ifdef EXEC_MUL_EN
        applyStimulus("mul", OP_MUL, 64'd6, 64'd7, 5'd9, 1'b1, 64'd42, 4'b0000, 1'b1);
        @(negedge clock);
        checkOutput("mul_busy", 64'(bus.busy), 64'd1);
        stall = 0;
        while (!bus.in_ready && stall < 200) begin
            stall++;
            @(negedge clock);
        end
        checkOutput("mul_stall_cycles", 64'(stall), 64'd64);
        applyStimulus("pass_b", OP_PASS, 64'd0, 64'h1234, 5'd7, 1'b1, 64'h1234, 4'b0000, 1'b1);
        drainQueue();
        // Second multiply is killed by reset partway through; it must never write.
        applyStimulus("mul_abort", OP_MUL, 64'd3, 64'd3, 5'd13, 1'b1, 64'd9, 4'b0000, 1'b0);
        repeat (20) @(negedge clock);
        pulseReset("mid_mul_reset");
        repeat (70) @(negedge clock);
`else
        stall = 0;
        applyStimulus("mul_as_unknown", OP_MUL, 64'd6, 64'd7, 5'd9, 1'b1, 64'd0, 4'b0000, 1'b1);
        checkOutput("nomul_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("nomul_busy", 64'(bus.busy), 64'd0);
        applyStimulus("pass_b", OP_PASS, 64'd0, 64'h1234, 5'd7, 1'b1, 64'h1234, 4'b0000, 1'b1);
        drainQueue();
        pulseReset("mid_run_reset");
`endif
        applyStimulus("add_after_reset", OP_ADD, 64'd1, 64'd1, 5'd2, 1'b1, 64'd2, 4'b0000, 1'b1);
        drainQueue();
        repeat (2) @(negedge clock);

        $display("%0d/%0d checks passed", passCount, totalChecks);
        $finish;
    end
endmodule
